// File: rtl/axil_master_port_if.sv
// AXI4-Lite master-side bus bundle for axil_master_port.
// The master modport is used by the initiator; the slave modport by whatever
// sits on the far side (interconnect, or a bench driving the slave signals).
interface axil_master_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    // write address channel
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    // write data channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    // write response channel
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // read address channel
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    // read data channel
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_master_port.sv
// Single-outstanding AXI4-Lite initiator: converts a valid/ready CPU memory
// request into one AXI-Lite read or write and returns the result on a
// registered valid/ready response channel.
// Optional feature: define AXIL_MASTER_TIMEOUT_EN to build a watchdog that
// aborts a transaction stuck for TIMEOUT_CYCLES cycles with rsp_err = 1.
module axil_master_port #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    // CPU request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    // CPU response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // AXI4-Lite master bus
    axil_master_port_if.master    m_axil
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               busy;
`endif

    // Every bus-facing valid/ready is a pure decode of registered state, so a
    // reset or abort edge clears them all at once.
    always_comb begin
        req_ready      = (state_q == IDLE);
        rsp_valid      = (state_q == RESP);
        rsp_rdata      = rsp_rdata_q;
        rsp_err        = rsp_err_q;
        m_axil.awaddr  = addr_q;
        m_axil.awprot  = 3'b000;
        m_axil.awvalid = (state_q == WR_REQ) && !aw_done_q;
        m_axil.wdata   = wdata_q;
        m_axil.wstrb   = wstrb_q;
        m_axil.wvalid  = (state_q == WR_REQ) && !w_done_q;
        m_axil.bready  = (state_q == WR_RESP);
        m_axil.araddr  = addr_q;
        m_axil.arprot  = 3'b000;
        m_axil.arvalid = (state_q == RD_REQ);
        m_axil.rready  = (state_q == RD_RESP);
    end

    // Next-state logic: request capture, AW/W completion tracking, response capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (m_axil.awvalid && m_axil.awready) begin
                    aw_done_d = 1'b1;
                end
                if (m_axil.wvalid && m_axil.wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil.bvalid) begin
                    rsp_err_d   = m_axil.bresp[1];
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end
            end
            RD_REQ: begin
                if (m_axil.arready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axil.rvalid) begin
                    rsp_rdata_d = m_axil.rdata;
                    rsp_err_d   = m_axil.rresp[1];
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
        // The watchdog overrides any progress made on the expiring cycle.
        if (busy && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1))) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end
`endif
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Watchdog counter: held at zero in IDLE, counts every cycle an AXI phase is pending.
    always_comb begin
        busy    = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_RESP);
        timer_d = timer_q;
        if (state_q == IDLE) begin
            timer_d = '0;
        end else if (busy) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_axil_master_port.sv
// Directed testbench for axil_master_port; the bench plays the AXI-Lite slave.
// Define AXIL_MASTER_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_axil_master_port;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int checks = 0;
    int errors = 0;

    axil_master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) m_axil ();

    axil_master_port #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .STRB_WIDTH    (SW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .m_axil   (m_axil)
    );

    // 100 MHz clock
    always #5 aclk = ~aclk;

    // advance one clock and settle away from the edge
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // checks that every AXI valid/ready driven by the master is low
    task automatic expect_bus_quiet(input string tag);
        checks++;
        if ({m_axil.awvalid, m_axil.wvalid, m_axil.bready, m_axil.arvalid, m_axil.rready} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL %s bus_quiet: got aw/w/b/ar/r=%b expected 00000", tag,
                     {m_axil.awvalid, m_axil.wvalid, m_axil.bready, m_axil.arvalid, m_axil.rready});
        end
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL issue req_ready: got %b expected 1", req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        step();
        step();
        expect_bus_quiet("reset");
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset req_ready/rsp_valid/rsp_err: got %b expected 100", {req_ready, rsp_valid, rsp_err});
        end
        checks++;
        if (rsp_rdata !== 32'h0 || m_axil.awaddr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset data: got rdata=%h awaddr=%h expected 0/0", rsp_rdata, m_axil.awaddr);
        end
        areset = 1'b0;
        step();
    endtask

    task automatic test_write_zero_wait();
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        // cycle N+1
        checks++;
        if ({m_axil.awvalid, m_axil.wvalid, m_axil.bready, req_ready} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL wr0 valids: got aw/w/b/req_ready=%b expected 1100",
                     {m_axil.awvalid, m_axil.wvalid, m_axil.bready, req_ready});
        end
        checks++;
        if (m_axil.awaddr !== 32'h10 || m_axil.wdata !== 32'hDEAD_BEEF || m_axil.wstrb !== 4'hF ||
            m_axil.awprot !== 3'b000) begin
            errors++;
            $display("[TB] FAIL wr0 payload: got %h %h %h %b expected 00000010 deadbeef f 000",
                     m_axil.awaddr, m_axil.wdata, m_axil.wstrb, m_axil.awprot);
        end
        m_axil.awready = 1'b1;
        m_axil.wready  = 1'b1;
        step();
        m_axil.awready = 1'b0;
        m_axil.wready  = 1'b0;
        // cycle N+2
        checks++;
        if ({m_axil.awvalid, m_axil.wvalid, m_axil.bready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL wr0 resp_phase: got aw/w/b=%b expected 001", {m_axil.awvalid, m_axil.wvalid, m_axil.bready});
        end
        m_axil.bvalid = 1'b1;
        m_axil.bresp  = 2'b00;
        step();
        m_axil.bvalid = 1'b0;
        // cycle N+3
        checks++;
        if ({rsp_valid, rsp_err, req_ready} !== 3'b100 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wr0 rsp: got valid/err/req_ready=%b rdata=%h expected 100 00000000",
                     {rsp_valid, rsp_err, req_ready}, rsp_rdata);
        end
        expect_bus_quiet("wr0_rsp");
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL wr0 idle: got rsp_valid/req_ready=%b expected 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_read_wait();
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        // AR held while arready is low for 3 cycles
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_axil.arvalid !== 1'b1 || m_axil.araddr !== 32'h20 || m_axil.rready !== 1'b0 ||
                m_axil.arprot !== 3'b000) begin
                errors++;
                $display("[TB] FAIL rd_ar_hold[%0d]: got arvalid=%b araddr=%h rready=%b expected 1 00000020 0",
                         i, m_axil.arvalid, m_axil.araddr, m_axil.rready);
            end
            if (i == 2) m_axil.arready = 1'b1;
            step();
        end
        m_axil.arready = 1'b0;
        // 5 wait cycles with rready high and no rvalid
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({m_axil.arvalid, m_axil.rready, rsp_valid} !== 3'b010) begin
                errors++;
                $display("[TB] FAIL rd_wait[%0d]: got arvalid/rready/rsp_valid=%b expected 010",
                         i, {m_axil.arvalid, m_axil.rready, rsp_valid});
            end
            step();
        end
        m_axil.rvalid = 1'b1;
        m_axil.rdata  = 32'h1234_5678;
        m_axil.rresp  = 2'b00;
        step();
        m_axil.rvalid = 1'b0;
        m_axil.rdata  = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd_rsp: got valid=%b rdata=%h err=%b expected 1 12345678 0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_write_aw_late();
        issue(1'b1, 32'h0000_0044, 32'hA5A5_0F0F, 4'h3);
        m_axil.wready = 1'b1;
        // early bvalid must not be consumed before the write phase completes
        m_axil.bvalid = 1'b1;
        m_axil.bresp  = 2'b00;
        checks++;
        if ({m_axil.awvalid, m_axil.wvalid} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL awlate start: got aw/w=%b expected 11", {m_axil.awvalid, m_axil.wvalid});
        end
        step();
        m_axil.wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({m_axil.awvalid, m_axil.wvalid, m_axil.bready} !== 3'b100 || m_axil.awaddr !== 32'h44) begin
                errors++;
                $display("[TB] FAIL awlate hold[%0d]: got aw/w/b=%b awaddr=%h expected 100 00000044",
                         i, {m_axil.awvalid, m_axil.wvalid, m_axil.bready}, m_axil.awaddr);
            end
            if (i == 2) m_axil.awready = 1'b1;
            step();
        end
        m_axil.awready = 1'b0;
        checks++;
        if ({m_axil.awvalid, m_axil.wvalid, m_axil.bready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL awlate bready: got aw/w/b=%b expected 001", {m_axil.awvalid, m_axil.wvalid, m_axil.bready});
        end
        step();
        m_axil.bvalid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL awlate rsp: got valid/err=%b rdata=%h expected 10 00000000", {rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_read_error_backpressure();
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        m_axil.arready = 1'b1;
        step();
        m_axil.arready = 1'b0;
        m_axil.rvalid  = 1'b1;
        m_axil.rdata   = 32'hCAFE_F00D;
        m_axil.rresp   = 2'b10;
        step();
        m_axil.rvalid = 1'b0;
        m_axil.rdata  = 32'h1111_1111;
        m_axil.rresp  = 2'b00;
        // a pending request must not be accepted while the response is held
        req_valid = 1'b1;
        req_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rsp_valid, rsp_err, req_ready} !== 3'b110 || rsp_rdata !== 32'hCAFE_F00D) begin
                errors++;
                $display("[TB] FAIL rderr hold[%0d]: got valid/err/req_ready=%b rdata=%h expected 110 cafef00d",
                         i, {rsp_valid, rsp_err, req_ready}, rsp_rdata);
            end
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rderr release: got rsp_valid/req_ready=%b expected 01", {rsp_valid, req_ready});
        end
        expect_bus_quiet("rderr_release");
    endtask

    task automatic test_reset_mid_write();
        issue(1'b1, 32'h0000_0200, 32'h0BAD_F00D, 4'hF);
        m_axil.awready = 1'b1;
        m_axil.wready  = 1'b1;
        step();
        m_axil.awready = 1'b0;
        m_axil.wready  = 1'b0;
        checks++;
        if (m_axil.bready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid in_wr_resp: got bready=%b expected 1", m_axil.bready);
        end
        areset = 1'b1;
        step();
        areset = 1'b0;
        expect_bus_quiet("rstmid");
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || m_axil.awaddr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rstmid state: got req_ready/rsp_valid/rsp_err=%b awaddr=%h expected 100 00000000",
                     {req_ready, rsp_valid, rsp_err}, m_axil.awaddr);
        end
    endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int high_cycles;
        high_cycles = 0;
        issue(1'b0, 32'h0000_0300, 32'h0, 4'h0);
        for (int i = 0; i < 40 && m_axil.arvalid === 1'b1; i++) begin
            high_cycles++;
            step();
        end
        checks++;
        if (high_cycles !== 16) begin
            errors++;
            $display("[TB] FAIL timeout arvalid_cycles: got %0d expected 16", high_cycles);
        end
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL timeout rsp: got valid/err=%b rdata=%h expected 11 00000000", {rsp_valid, rsp_err}, rsp_rdata);
        end
        expect_bus_quiet("timeout");
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        areset         = 1'b1;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        req_wstrb      = '0;
        rsp_ready      = 1'b0;
        m_axil.awready = 1'b0;
        m_axil.wready  = 1'b0;
        m_axil.bresp   = 2'b00;
        m_axil.bvalid  = 1'b0;
        m_axil.arready = 1'b0;
        m_axil.rdata   = '0;
        m_axil.rresp   = 2'b00;
        m_axil.rvalid  = 1'b0;

        $display("[TB] starting axil_master_port bench");
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_write_aw_late();
        test_read_error_backpressure();
        test_reset_mid_write();
`ifdef AXIL_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
